// File: rtl/alu_muldiv_unit.sv
// Sequential ALU stage: single-cycle logic/arith ops plus 32-step MULTU/DIVU into HI/LO.
// Optional feature macro: MULDIV_DIV_EN enables the restoring divider datapath for DIVU.
module alu_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam int SW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] r_mq;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic [WIDTH-1:0] w_alu;
   logic [SW-1:0]    w_sh;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_mul_acc;
   logic [WIDTH-1:0] w_mul_mq;
   logic [WIDTH:0]   w_step_acc;
   logic [WIDTH-1:0] w_step_mq;
`ifdef MULDIV_DIV_EN
   logic [WIDTH:0]   w_div_shift;
   logic [WIDTH:0]   w_div_diff;
`endif

   assign w_sh = b[SW-1:0];

   // Single-cycle result; MULTU/DIVU codes never reach here, disabled DIVU yields zero
   always_comb begin
      w_alu = {WIDTH{1'b0}};
      case (op)
         4'd0:    w_alu = a & b;
         4'd1:    w_alu = a | b;
         4'd2:    w_alu = a + b;
         4'd3:    w_alu = a - b;
         4'd4:    w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         4'd5:    w_alu = ~(a | b);
         4'd6:    w_alu = a ^ b;
         4'd7:    w_alu = a << w_sh;
         4'd10:   w_alu = r_hi;
         4'd11:   w_alu = r_lo;
         default: w_alu = {WIDTH{1'b0}};
      endcase
   end

   // One iteration step: {acc,mq} shift-add for multiply, restoring subtract for divide
   always_comb begin
      w_mul_sum  = r_mq[0] ? (r_acc + {1'b0, r_opb}) : r_acc;
      w_mul_acc  = {1'b0, w_mul_sum[WIDTH:1]};
      w_mul_mq   = {w_mul_sum[0], r_mq[WIDTH-1:1]};
      w_step_acc = w_mul_acc;
      w_step_mq  = w_mul_mq;
`ifdef MULDIV_DIV_EN
      w_div_shift = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
      w_div_diff  = w_div_shift - {1'b0, r_opb};
      if (r_state == S_DIV) begin
         // A clear borrow bit means the trial subtraction fits; b == 0 always fits
         if (!w_div_diff[WIDTH]) begin
            w_step_acc = w_div_diff;
            w_step_mq  = {r_mq[WIDTH-2:0], 1'b1};
         end else begin
            w_step_acc = w_div_shift;
            w_step_mq  = {r_mq[WIDTH-2:0], 1'b0};
         end
      end else begin
         w_step_acc = w_mul_acc;
         w_step_mq  = w_mul_mq;
      end
`endif
   end

   // Next-state decode
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (op == 4'd8) begin
                  w_next_state = S_MUL;
`ifdef MULDIV_DIV_EN
               end else if (op == 4'd9) begin
                  w_next_state = S_DIV;
`endif
               end else begin
                  w_next_state = S_DONE;
               end
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_MUL: begin
            if (r_cnt == CW'(1)) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_MUL;
            end
         end
`ifdef MULDIV_DIV_EN
         S_DIV: begin
            if (r_cnt == CW'(1)) begin
               w_next_state = S_DONE;
            end else begin
               w_next_state = S_DIV;
            end
         end
`endif
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // State register with registered busy/done decoded from the next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state == S_MUL) || (w_next_state == S_DIV);
         r_done  <= (w_next_state == S_DONE);
      end
   end

   // Datapath: operand capture, iteration registers, HI/LO and result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt    <= {CW{1'b0}};
         r_acc    <= {(WIDTH+1){1'b0}};
         r_mq     <= {WIDTH{1'b0}};
         r_opb    <= {WIDTH{1'b0}};
         r_result <= {WIDTH{1'b0}};
         r_zero   <= 1'b0;
         r_hi     <= {WIDTH{1'b0}};
         r_lo     <= {WIDTH{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_next_state == S_DONE) begin
                     r_result <= w_alu;
                     r_zero   <= (w_alu == {WIDTH{1'b0}});
                  end else begin
                     r_acc <= {(WIDTH+1){1'b0}};
                     r_mq  <= a;
                     r_opb <= b;
                     r_cnt <= CW'(WIDTH);
                  end
               end
            end
            S_MUL, S_DIV: begin
               r_acc <= w_step_acc;
               r_mq  <= w_step_mq;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_hi     <= w_step_acc[WIDTH-1:0];
                  r_lo     <= w_step_mq;
                  r_result <= w_step_mq;
                  r_zero   <= (w_step_mq == {WIDTH{1'b0}});
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign result = r_result;
   assign zero   = r_zero;
   assign busy   = r_busy;
   assign done   = r_done;
   assign hi     = r_hi;
   assign lo     = r_lo;

endmodule

// File: doc/alu_muldiv_unit.md
# alu_muldiv_unit

Sequential ALU stage of the multicycle CPU. It accepts an operation and two 32-bit operands from the operand-select muxes under a start/done handshake and computes the result. Single-cycle ops finish in one cycle; multiply and divide iterate over 32 cycles into internal HI/LO registers. The registered result drives the ALU output register's input and the controller's branch-zero logic.

## Interface
Parameters:
- WIDTH, 32, operand/result width; counter width is clog2(WIDTH)+1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  4  operation code, sampled with start
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- result  output  WIDTH  registered result, held until next accepted op
- zero  output  1  registered, 1 when result == 0
- busy  output  1  1 in MUL or DIV state
- done  output  1  1 for exactly one cycle, in DONE state
- hi  output  WIDTH  HI register (product high / remainder)
- lo  output  WIDTH  LO register (product low / quotient)

Reset: clk and rst as above; one clock domain, asynchronous active-low reset.

## Operation
- Op codes:
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT (signed, result 1/0), 5 NOR, 6 XOR, 7 SLL (a << b[4:0]); all single-cycle.
  - 8 MULTU: unsigned, {hi,lo} = a*b.
  - 9 DIVU: unsigned, lo = a/b, hi = a%b.
  - 10 MFHI: result = hi. 11 MFLO: result = lo.
  - 12-15: result = 0, single-cycle.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- States: IDLE, MUL, DIV, DONE.
  - IDLE + start + single-cycle op → DONE; result and zero are written on that edge.
  - IDLE + start + op 8 → MUL; IDLE + start + op 9 → DIV. On that edge a/b are latched and the counter is loaded with WIDTH.
  - MUL/DIV: one shift-add or restoring-subtract step per cycle; counter decrements. On the edge where the counter reaches 0 → DONE; hi/lo are written and result = lo.
  - DONE → IDLE unconditionally on the next edge.
- start outside IDLE is ignored; no queuing. Operands may change freely after acceptance.
- Divide by zero: no trap and same 32-cycle latency; lo = all ones, hi = a.
- hi/lo change only on MULTU/DIVU completion. result/zero change only on the accepting edge (single-cycle) or the completing edge (MUL/DIV).

## Timing
- All outputs reset to 0, state IDLE, counter 0. Reset is asynchronous assert, synchronous-safe deassert.
- Reset mid-MUL/DIV aborts: partial state is discarded and hi/lo return to 0.
- Single-cycle op, start sampled at edge k: result/zero valid and done=1 after edge k; IDLE after edge k+1.
- MULTU/DIVU, start sampled at edge k: busy=1 from after edge k to after edge k+31. result/hi/lo valid and done=1 after edge k+32; IDLE after edge k+33.
- Back-to-back: the earliest next acceptance is the edge where DONE→IDLE plus one, i.e. start must be high in the IDLE cycle.
- done and busy are never simultaneously 1.

## Configuration
- MULDIV_DIV_EN
  - Defined: DIVU implemented as above.
  - Not defined: no divider datapath is synthesized. Op 9 behaves as a single-cycle op with result = 0, and hi/lo are unchanged.

## Test plan
- Reset: assert rst=0 mid-MULTU (a=7, b=9, cycle 10) → all outputs 0, IDLE; after release, MFLO → result 0.
- ADD a=0xFFFFFFFF, b=1 → result 0, zero=1, done one cycle after the start edge. SLT a=0x80000000, b=1 → result 1.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done after exactly 32 cycles, hi=0xFFFFFFFE, lo=0x00000001, busy high 32 cycles.
- DIVU a=100, b=7 → lo=14, hi=2. DIVU a=5, b=0 → lo=0xFFFFFFFF, hi=5. Without MULDIV_DIV_EN: result 0 in 1 cycle, hi/lo unchanged.
- start pulsed during MUL with op=2 → ignored; the final result is the product. MFHI issued in the IDLE cycle right after → returns the new hi.
